cpu_debug_ctrl: RTL and testbench

Board-level controller that schedules CPU execution via a single-cycle clock-enable (cpuEn), replacing free-running divided clocks in debug top-levels. Provides RUN/HALT/STEP control from debounced buttons and a programmable run rate. Drives the register-file debug read port and registers one 16-bit half of the selected register onto LEDs. Sits between board buttons/LEDs and the CPU top instance.

---
 rtl/cpu_debug_ctrl_pkg.sv | 10 +
 rtl/cpu_debug_ctrl_button_debounce.sv | 32 +++
 rtl/cpu_debug_ctrl.sv | 96 +++++++++
 tb/tb_cpu_debug_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_ctrl_pkg.sv
// cpu_debug_ctrl_pkg: shared state encoding and widths for the debug controller
package cpu_debug_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;
  localparam int RF_ADDR_W = 5;
  localparam int LED_W = 16;
endpackage

// File: rtl/cpu_debug_ctrl_button_debounce.sv
// button_debounce: 2-FF synchronizer, stability counter, one-cycle pulse per accepted press
module button_debounce
  import cpu_debug_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic sysClk,
  input  logic sysRes,
  input  logic btnIn,
  output logic pressPulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic level;
  logic [CW-1:0] cnt;
  logic settle;
  assign settle = (sync[1] != level) && (cnt == LAST);
  // level flips only after the synchronized input differs for DEBOUNCE_CYCLES cycles
  always_ff @(posedge sysClk)
    if (!sysRes) begin
      sync <= '0;
      level <= 1'b0;
      cnt <= '0;
      pressPulse <= 1'b0;
    end else begin
      sync <= {sync[0], btnIn};
      cnt <= (sync[1] == level || settle) ? '0 : cnt + 1'b1;
      if (settle) level <= sync[1];
      pressPulse <= settle && sync[1];
    end
endmodule

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: RUN/HALT/STEP cpuEn scheduler with register display; breakpoint via CPU_DEBUG_BKPT_EN
module cpu_debug_ctrl
  import cpu_debug_ctrl_pkg::*;
#(
  parameter int DIV_W = 24,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_RUN = 1
) (
  input  logic                 sysClk,
  input  logic                 sysRes,
  input  logic                 btnRun,
  input  logic                 btnStep,
  input  logic                 btnSel,
  input  logic                 swHalf,
  input  logic [DIV_W-1:0]     rateDiv,
  input  logic [31:0]          rfData,
  output logic                 cpuEn,
  output logic [RF_ADDR_W-1:0] rfAddr,
  output logic [LED_W-1:0]     ledOut,
  output logic [15:0]          stepCount,
`ifdef CPU_DEBUG_BKPT_EN
  input  logic [31:0]          pc,
  input  logic [31:0]          bkptAddr,
  input  logic [0:0]           bkptEn,
  output logic                 bkptHit,
`endif
  output logic                 running
);
  state_t state;
  logic [DIV_W-1:0] div;
  logic runP, stepP, selP, bkptFire;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRun (
    .sysClk(sysClk), .sysRes(sysRes), .btnIn(btnRun), .pressPulse(runP));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStep (
    .sysClk(sysClk), .sysRes(sysRes), .btnIn(btnStep), .pressPulse(stepP));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSel (
    .sysClk(sysClk), .sysRes(sysRes), .btnIn(btnSel), .pressPulse(selP));

`ifdef CPU_DEBUG_BKPT_EN
  logic bkptMask;
  assign bkptFire = bkptEn[0] && (pc == bkptAddr) && !bkptMask;
  // sticky hit flag; mask lets the breakpoint instruction execute once after resume
  always_ff @(posedge sysClk)
    if (!sysRes) begin
      bkptHit <= 1'b0;
      bkptMask <= 1'b0;
    end else if (state == ST_HALT && runP) begin
      bkptHit <= 1'b0;
      bkptMask <= 1'b1;
    end else begin
      if (state == ST_RUN && !runP && bkptFire) bkptHit <= 1'b1;
      if (cpuEn) bkptMask <= 1'b0;
    end
`else
  assign bkptFire = 1'b0;
`endif

  // control FSM; divider is cleared whenever not counting so RUN restarts a full period
  always_ff @(posedge sysClk)
    if (!sysRes) begin
      state <= (RESET_RUN != 0) ? ST_RUN : ST_HALT;
      running <= (RESET_RUN != 0);
      div <= '0;
      cpuEn <= 1'b0;
    end else begin
      cpuEn <= 1'b0;
      div <= '0;
      if (state == ST_RUN) begin
        if (runP || bkptFire) begin
          state <= ST_HALT;
          running <= 1'b0;
        end else if (div >= rateDiv) cpuEn <= 1'b1;
        else div <= div + 1'b1;
      end else if (state == ST_STEP) state <= ST_HALT;
      else if (runP) begin
        state <= ST_RUN;
        running <= 1'b1;
      end else if (stepP) begin
        state <= ST_STEP;
        cpuEn <= 1'b1;
      end
    end

  // issued-pulse counter, register select and LED capture
  always_ff @(posedge sysClk)
    if (!sysRes) begin
      stepCount <= '0;
      rfAddr <= '0;
      ledOut <= '0;
    end else begin
      stepCount <= stepCount + {15'd0, cpuEn};
      if (selP) rfAddr <= rfAddr + 1'b1;
      ledOut <= swHalf ? rfData[31:16] : rfData[15:0];
    end
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb_cpu_debug_ctrl: directed self-checking bench for cpu_debug_ctrl (DEBOUNCE_CYCLES=4, RESET_RUN=1)
module tb_cpu_debug_ctrl;
  logic sysClk = 1'b0;
  logic sysRes, btnRun, btnStep, btnSel, swHalf;
  logic [23:0] rateDiv;
  logic [31:0] rfData;
  logic cpuEn, running;
  logic [4:0] rfAddr;
  logic [15:0] ledOut, stepCount;
  int errors = 0;
  int checks = 0;
`ifdef CPU_DEBUG_BKPT_EN
  logic [31:0] pc, bkptAddr;
  logic [0:0] bkptEn;
  logic bkptHit;
  always @(posedge sysClk)
    if (!sysRes) pc <= 32'd0;
    else if (cpuEn) pc <= pc + 32'd4;
`endif

  always #5 sysClk = ~sysClk;

  cpu_debug_ctrl #(.DIV_W(24), .DEBOUNCE_CYCLES(4), .RESET_RUN(1)) dut (
    .sysClk(sysClk), .sysRes(sysRes), .btnRun(btnRun), .btnStep(btnStep), .btnSel(btnSel),
    .swHalf(swHalf), .rateDiv(rateDiv), .rfData(rfData), .cpuEn(cpuEn), .rfAddr(rfAddr),
    .ledOut(ledOut), .stepCount(stepCount),
`ifdef CPU_DEBUG_BKPT_EN
    .pc(pc), .bkptAddr(bkptAddr), .bkptEn(bkptEn), .bkptHit(bkptHit),
`endif
    .running(running));

  task automatic test_reset();
    sysRes = 1'b0; btnRun = 1'b0; btnStep = 1'b0; btnSel = 1'b0; swHalf = 1'b0;
    rateDiv = 24'd3; rfData = 32'h1234_5678;
`ifdef CPU_DEBUG_BKPT_EN
    bkptAddr = 32'h0; bkptEn = 1'b0;
`endif
    repeat (3) @(negedge sysClk);
    checks++; if (cpuEn !== 1'b0) begin errors++; $display("FAIL reset_cpuEn got=%b exp=0", cpuEn); end
    checks++; if (rfAddr !== 5'd0) begin errors++; $display("FAIL reset_rfAddr got=%0d exp=0", rfAddr); end
    checks++; if (ledOut !== 16'h0) begin errors++; $display("FAIL reset_ledOut got=%h exp=0000", ledOut); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_running got=%b exp=1", running); end
    checks++; if (stepCount !== 16'd0) begin errors++; $display("FAIL reset_stepCount got=%0d exp=0", stepCount); end
    rfData = 32'h0;
    sysRes = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge sysClk);
      checks++;
      if (cpuEn !== (k % 4 == 0)) begin
        errors++; $display("FAIL reset_cadence k=%0d got=%b exp=%b", k, cpuEn, (k % 4 == 0));
      end
    end
    checks++; if (stepCount !== 16'd2) begin errors++; $display("FAIL cadence_stepCount got=%0d exp=2", stepCount); end
  endtask

  task automatic test_run_toggle();
    int hits = 0;
    int runs = 0;
    btnRun = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sysClk);
      if (k == 6) begin checks++; if (running !== 1'b1) begin errors++; $display("FAIL toggle_before got=%b exp=1", running); end end
      if (k == 7) begin checks++; if (running !== 1'b0) begin errors++; $display("FAIL toggle_at got=%b exp=0", running); end end
      if (k >= 7) hits += int'(cpuEn);
    end
    btnRun = 1'b0;
    repeat (10) @(negedge sysClk);
    checks++; if (hits != 0) begin errors++; $display("FAIL toggle_halted_cpuEn got=%0d exp=0", hits); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL toggle_single got=%b exp=0", running); end
    checks++; if (stepCount !== 16'd4) begin errors++; $display("FAIL toggle_stepCount got=%0d exp=4", stepCount); end
    hits = 0;
    for (int i = 0; i < 24; i++) begin
      btnRun = (i == 0 || i == 10 || i == 11);
      @(negedge sysClk);
      hits += int'(cpuEn);
      runs += int'(running);
    end
    btnRun = 1'b0;
    checks++; if (runs != 0 || hits != 0) begin errors++; $display("FAIL bounce running=%0d cpuEn=%0d exp=0/0", runs, hits); end
  endtask

  task automatic test_step();
    for (int p = 0; p < 3; p++) begin
      int hits = 0;
      btnStep = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge sysClk);
        hits += int'(cpuEn);
        if (k == 7) begin checks++; if (cpuEn !== 1'b1) begin errors++; $display("FAIL step_pulse p=%0d got=%b exp=1", p, cpuEn); end end
      end
      btnStep = 1'b0;
      repeat (8) begin @(negedge sysClk); hits += int'(cpuEn); end
      checks++; if (hits != 1) begin errors++; $display("FAIL step_count p=%0d got=%0d exp=1", p, hits); end
    end
    checks++; if (stepCount !== 16'd7) begin errors++; $display("FAIL step_stepCount got=%0d exp=7", stepCount); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_halted got=%b exp=0", running); end
  endtask

  task automatic test_back_to_back();
    btnRun = 1'b1; btnStep = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge sysClk);
      if (k == 7) begin checks++; if (running !== 1'b1) begin errors++; $display("FAIL both_running got=%b exp=1", running); end end
      if (k >= 7 && k <= 10) begin checks++; if (cpuEn !== 1'b0) begin errors++; $display("FAIL both_nostep k=%0d got=%b exp=0", k, cpuEn); end end
      if (k == 11) begin checks++; if (cpuEn !== 1'b1) begin errors++; $display("FAIL both_first_run got=%b exp=1", cpuEn); end end
    end
    btnRun = 1'b0; btnStep = 1'b0;
    repeat (8) @(negedge sysClk);
  endtask

  task automatic test_select();
    for (int i = 0; i < 33; i++) begin
      btnSel = 1'b1;
      repeat (7) @(negedge sysClk);
      btnSel = 1'b0;
      repeat (7) @(negedge sysClk);
      if (i == 0) begin checks++; if (rfAddr !== 5'd1) begin errors++; $display("FAIL sel_first got=%0d exp=1", rfAddr); end end
      if (i == 31) begin checks++; if (rfAddr !== 5'd0) begin errors++; $display("FAIL sel_wrap got=%0d exp=0", rfAddr); end end
    end
    checks++; if (rfAddr !== 5'd1) begin errors++; $display("FAIL sel_33 got=%0d exp=1", rfAddr); end
    rfData = 32'hDEAD_BEEF; swHalf = 1'b1;
    #1;
    checks++; if (ledOut !== 16'h0000) begin errors++; $display("FAIL led_latency got=%h exp=0000", ledOut); end
    @(negedge sysClk);
    checks++; if (ledOut !== 16'hDEAD) begin errors++; $display("FAIL led_high got=%h exp=dead", ledOut); end
    swHalf = 1'b0;
    @(negedge sysClk);
    checks++; if (ledOut !== 16'hBEEF) begin errors++; $display("FAIL led_low got=%h exp=beef", ledOut); end
  endtask

  task automatic test_rate();
    rateDiv = 24'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge sysClk);
      checks++; if (cpuEn !== 1'b1) begin errors++; $display("FAIL rate0 k=%0d got=%b exp=1", k, cpuEn); end
    end
    rateDiv = 24'd10;
    for (int k = 1; k <= 14; k++) begin
      @(negedge sysClk);
      checks++;
      if (cpuEn !== (k == 8 || k == 11 || k == 14)) begin
        errors++; $display("FAIL rate_change k=%0d got=%b exp=%b", k, cpuEn, (k == 8 || k == 11 || k == 14));
      end
      if (k == 7) rateDiv = 24'd2;
    end
  endtask

  task automatic test_midrun_reset();
    btnRun = 1'b1;
    repeat (8) @(negedge sysClk);
    btnRun = 1'b0;
    repeat (8) @(negedge sysClk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL prereset_halt got=%b exp=0", running); end
    sysRes = 1'b0;
    @(negedge sysClk);
    checks++; if (cpuEn !== 1'b0) begin errors++; $display("FAIL midreset_cpuEn got=%b exp=0", cpuEn); end
    checks++; if (rfAddr !== 5'd0) begin errors++; $display("FAIL midreset_rfAddr got=%0d exp=0", rfAddr); end
    checks++; if (ledOut !== 16'h0) begin errors++; $display("FAIL midreset_ledOut got=%h exp=0000", ledOut); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL midreset_running got=%b exp=1", running); end
    checks++; if (stepCount !== 16'd0) begin errors++; $display("FAIL midreset_stepCount got=%0d exp=0", stepCount); end
    sysRes = 1'b1;
  endtask

`ifdef CPU_DEBUG_BKPT_EN
  task automatic test_bkpt();
    int t = 0;
    sysRes = 1'b0; rateDiv = 24'd1; bkptAddr = 32'h20; bkptEn = 1'b1;
    repeat (2) @(negedge sysClk);
    sysRes = 1'b1;
    @(negedge sysClk);
    checks++; if (bkptHit !== 1'b0) begin errors++; $display("FAIL bkpt_reset got=%b exp=0", bkptHit); end
    while (bkptHit !== 1'b1 && t < 100) begin @(negedge sysClk); t++; end
    checks++; if (t >= 100) begin errors++; $display("FAIL bkpt_timeout got=%0d exp<100", t); end
    checks++; if (pc !== 32'h20 || running !== 1'b0 || cpuEn !== 1'b0) begin
      errors++; $display("FAIL bkpt_halt pc=%h running=%b cpuEn=%b exp=20/0/0", pc, running, cpuEn);
    end
    repeat (5) @(negedge sysClk);
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL bkpt_hold got=%h exp=20", pc); end
    btnRun = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sysClk);
      if (k == 7) begin checks++; if (bkptHit !== 1'b0 || running !== 1'b1) begin
        errors++; $display("FAIL bkpt_resume hit=%b running=%b exp=0/1", bkptHit, running);
      end end
    end
    btnRun = 1'b0;
    t = 0;
    while (pc !== 32'h30 && t < 60) begin @(negedge sysClk); t++; end
    checks++; if (t >= 60 || running !== 1'b1 || bkptHit !== 1'b0) begin
      errors++; $display("FAIL bkpt_continue pc=%h running=%b hit=%b exp=30/1/0", pc, running, bkptHit);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_toggle();
    test_step();
    test_back_to_back();
    test_select();
    test_rate();
    test_midrun_reset();
`ifdef CPU_DEBUG_BKPT_EN
    test_bkpt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
